// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: periodic channel-scan sequencer for the LTC2308 converter
// interface. For each channel set in ch_mask it issues 2^AVG_LOG2
// conversions, averages the results and publishes them to a result bank.
//
// Handshake to the converter: measure_ch is driven one cycle before
// measure_start rises, and measure_start is always low for at least one cycle
// before each rising edge. measure_start stays high until measure_done (a
// one-cycle pulse) is seen or the wait times out. measure_done is honoured
// only while waiting.
module adc_scan_ctrl #(
  parameter int AVG_LOG2    = 2,
  parameter int SCAN_PERIOD = 40000,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  ch_mask,
  output logic        measure_start,
  output logic [2:0]  measure_ch,
  input  logic        measure_done,
  input  logic [11:0] measure_dataread,
  input  logic [2:0]  rd_ch,
  output logic [11:0] rd_data,
  output logic        rd_valid,
  output logic        scan_done,
  output logic        timeout_err,
  input  logic        err_clr
);

  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int NSAMP = 1 << AVG_LOG2;
  localparam int PER_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_START, S_WAIT, S_STORE, S_NEXT
  } state_t;

  state_t            state_q;
  logic              ms_q, scan_done_q, terr_q, pend_q, pend_d, enable_q;
  logic [2:0]        mch_q, cur_ch_q;
  logic [7:0]        scan_mask_q, valid_q;
  logic [CNT_W-1:0]  samp_q, samp_inc;
  logic [ACC_W-1:0]  acc_q;
  logic [TO_W-1:0]   to_q;
  logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
  logic [11:0]       bank_q [8];
  logic [11:0]       rd_data_q;
  logic              rd_valid_q;
  logic              per_wrap, scan_req, consume;
  logic [3:0]        first_hit, next_hit;

  // {found, channel} of the lowest set bit of mask above cur (or at cur if incl)
  function automatic logic [3:0] find_ch(input logic [7:0] mask,
                                         input logic [2:0] cur,
                                         input logic incl);
    logic [3:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && ((i > int'(cur)) || (incl && (i == int'(cur)))))
        r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // Period counter next state, scan request and pending-request bookkeeping
  always_comb begin
    per_wrap  = enable && (per_cnt_q == PER_W'(SCAN_PERIOD - 1));
    per_cnt_d = (!enable || per_wrap) ? '0 : per_cnt_q + PER_W'(1);
    scan_req  = per_wrap || (enable && !enable_q);
    consume   = (state_q == S_IDLE) && enable && pend_q;
    pend_d    = enable ? ((pend_q && !consume) || scan_req) : 1'b0;
    first_hit = find_ch(ch_mask, 3'd0, 1'b1);
    next_hit  = find_ch(scan_mask_q, cur_ch_q, 1'b0);
    samp_inc  = samp_q + CNT_W'(1);
  end

  // Free-running scan period counter, held at zero while disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      per_cnt_q <= '0;
      enable_q  <= 1'b0;
    end else begin
      per_cnt_q <= per_cnt_d;
      enable_q  <= enable;
    end
  end

  // Scan sequencer FSM with registered converter outputs and result bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ms_q        <= 1'b0;
      mch_q       <= '0;
      scan_done_q <= 1'b0;
      terr_q      <= 1'b0;
      pend_q      <= 1'b0;
      scan_mask_q <= '0;
      cur_ch_q    <= '0;
      samp_q      <= '0;
      acc_q       <= '0;
      to_q        <= '0;
      valid_q     <= '0;
      for (int i = 0; i < 8; i++) bank_q[i] <= '0;
    end else begin
      scan_done_q <= 1'b0;
      pend_q      <= pend_d;
      // a timeout later in this block overrides the clear
      if (err_clr) terr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ms_q <= 1'b0;
          // an all-zero mask consumes (drops) the request without starting
          if (consume && first_hit[3]) begin
            scan_mask_q <= ch_mask;
            cur_ch_q    <= first_hit[2:0];
            samp_q      <= '0;
            acc_q       <= '0;
            state_q     <= S_SELECT;
          end
        end
        S_SELECT: begin
          ms_q  <= 1'b0;
          mch_q <= cur_ch_q;
          to_q  <= '0;
          state_q <= enable ? S_START : S_NEXT;
        end
        S_START: begin
          ms_q    <= 1'b1;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          to_q <= to_q + TO_W'(1);
          if (measure_done) begin
            acc_q   <= acc_q + ACC_W'(measure_dataread);
            ms_q    <= 1'b0;
            state_q <= S_STORE;
          end else if (to_q == TO_W'(TIMEOUT - 1)) begin
            terr_q  <= 1'b1;
            ms_q    <= 1'b0;
            state_q <= S_NEXT;
          end
        end
        S_STORE: begin
          ms_q   <= 1'b0;
          samp_q <= samp_inc;
          if (!enable) begin
            // scan abandoned: nothing written, NEXT returns to IDLE
            state_q <= S_NEXT;
          end else if (samp_inc < CNT_W'(NSAMP)) begin
            state_q <= S_SELECT;
          end else begin
            bank_q[cur_ch_q]  <= acc_q[AVG_LOG2 +: 12];
            valid_q[cur_ch_q] <= 1'b1;
            acc_q   <= '0;
            state_q <= S_NEXT;
          end
        end
        S_NEXT: begin
          samp_q <= '0;
          acc_q  <= '0;
          if (!enable) begin
            state_q <= S_IDLE;
          end else if (next_hit[3]) begin
            cur_ch_q <= next_hit[2:0];
            state_q  <= S_SELECT;
          end else begin
            scan_done_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Registered read port; a same-cycle bank write is seen one cycle later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= bank_q[rd_ch];
      rd_valid_q <= valid_q[rd_ch];
    end
  end

  assign measure_start = ms_q;
  assign measure_ch    = mch_q;
  assign scan_done     = scan_done_q;
  assign timeout_err   = terr_q;
  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Bench for adc_scan_ctrl: converter model, vector table, corner sequences.
module tb_adc_scan_ctrl;

  localparam int P   = 3000;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset, enable, err_clr;
  logic [7:0]  ch_mask;
  logic [2:0]  rd_ch;
  logic        measure_start, scan_done, timeout_err, rd_valid;
  logic [2:0]  measure_ch;
  logic [11:0] rd_data;
  logic        measure_done = 1'b0;
  logic [11:0] measure_dataread = '0;

  adc_scan_ctrl #(.AVG_LOG2(2), .SCAN_PERIOD(P), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask),
    .measure_start(measure_start), .measure_ch(measure_ch),
    .measure_done(measure_done), .measure_dataread(measure_dataread),
    .rd_ch(rd_ch), .rd_data(rd_data), .rd_valid(rd_valid),
    .scan_done(scan_done), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // converter model state (written only by the model process)
  logic [11:0] mdl_vals [8][4];
  logic [7:0]  mdl_mute = '0;
  int          mdl_k [8];
  int          edge_cnt = 0, sd_cnt = 0, viol = 0;
  int          inject_req = 0, inject_ack = 0;
  logic [2:0]  ch_log [$];
  logic        prev_start = 1'b0;
  logic [2:0]  prev_ch = '0;
  bit          m_pend = 0;
  int          m_dly = 0;
  logic [2:0]  m_ch = '0;

  // converter model: done pulse LAT cycles after each rising edge of start
  always @(negedge clk) begin
    measure_done = 1'b0;
    if (reset) begin
      m_pend = 0;
      prev_start = 1'b0;
      for (int k = 0; k < 8; k++) mdl_k[k] = 0;
    end else begin
      if (measure_start && !prev_start) begin
        edge_cnt++;
        ch_log.push_back(measure_ch);
        if (measure_ch !== prev_ch) viol++;
        m_pend = 1; m_dly = LAT; m_ch = measure_ch;
      end else if (m_pend) begin
        if (m_dly == 0) begin
          m_pend = 0;
          if (!mdl_mute[m_ch]) begin
            measure_done = 1'b1;
            measure_dataread = mdl_vals[m_ch][mdl_k[m_ch] % 4];
            mdl_k[m_ch]++;
          end
        end else m_dly--;
      end
      if (inject_ack != inject_req) begin
        inject_ack = inject_req;
        measure_done = 1'b1;
        measure_dataread = 12'hABC;
      end
      if (scan_done) sd_cnt++;
      prev_start = measure_start;
      prev_ch = measure_ch;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; err_clr = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic set_vals(input int ch, input logic [11:0] a, b, c, d);
    mdl_vals[ch][0] = a; mdl_vals[ch][1] = b;
    mdl_vals[ch][2] = c; mdl_vals[ch][3] = d;
  endtask

  task automatic run_scan(input logic [7:0] mask, input int budget, output bit ok);
    int sd0;
    sd0 = sd_cnt;
    enable = 1'b0; ch_mask = mask;
    tick(2);
    enable = 1'b1;
    for (int i = 0; i < budget && sd_cnt == sd0; i++) tick(1);
    ok = (sd_cnt != sd0);
    tick(2);
    enable = 1'b0;
    tick(2);
  endtask

  task automatic read_ch(input logic [2:0] ch, output logic [11:0] d, output logic v);
    rd_ch = ch;
    tick(1);
    d = rd_data; v = rd_valid;
  endtask

  typedef struct packed {
    logic [2:0]  ch;
    logic [11:0] v0, v1, v2, v3;
    logic [11:0] exp;
  } vec_t;

  vec_t        vecs [6];
  logic [2:0]  exp_q [$];
  logic [11:0] d;
  logic        v;
  logic [7:0]  vpat;
  bit          ok;
  int          e0, sd0, lb, bad;

  initial begin
    vecs[0] = '{3'd0, 12'd100,  12'd101,  12'd102,  12'd103,  12'd101};
    vecs[1] = '{3'd6, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095};
    vecs[2] = '{3'd1, 12'd0,    12'd0,    12'd0,    12'd3,    12'd0};
    vecs[3] = '{3'd7, 12'd1,    12'd2,    12'd2,    12'd2,    12'd1};
    vecs[4] = '{3'd3, 12'd4095, 12'd4095, 12'd4095, 12'd4094, 12'd4094};
    vecs[5] = '{3'd2, 12'd10,   12'd20,   12'd30,   12'd41,   12'd25};
    for (int c = 0; c < 8; c++) set_vals(c, 12'd0, 12'd0, 12'd0, 12'd0);

    reset = 1'b1; enable = 1'b0; ch_mask = '0; rd_ch = '0; err_clr = 1'b0;
    tick(3);
    check("rst_start", measure_start, 0);
    check("rst_ch", measure_ch, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_timeout_err", timeout_err, 0);
    reset = 1'b0;
    tick(1);

    // table-driven single-channel scans
    for (int i = 0; i < 6; i++) begin
      set_vals(vecs[i].ch, vecs[i].v0, vecs[i].v1, vecs[i].v2, vecs[i].v3);
      e0 = edge_cnt; sd0 = sd_cnt; lb = ch_log.size();
      run_scan(8'(1 << vecs[i].ch), 500, ok);
      check("vec_scan_done_seen", ok, 1);
      check("vec_starts", edge_cnt - e0, 4);
      check("vec_scan_done_once", sd_cnt - sd0, 1);
      bad = 0;
      for (int j = lb; j < ch_log.size(); j++) if (ch_log[j] !== vecs[i].ch) bad++;
      check("vec_channel", bad, 0);
      read_ch(vecs[i].ch, d, v);
      check("vec_rd_data", d, vecs[i].exp);
      check("vec_rd_valid", v, 1);
    end

    // three channels, ascending order, valid bits only where scanned
    do_reset();
    set_vals(2, 12'd1, 12'd2, 12'd3, 12'd4);
    set_vals(5, 12'd200, 12'd200, 12'd200, 12'd200);
    set_vals(7, 12'd4000, 12'd4001, 12'd4002, 12'd4003);
    lb = ch_log.size();
    run_scan(8'hA4, 1000, ok);
    check("a4_scan_done_seen", ok, 1);
    exp_q.delete();
    repeat (4) exp_q.push_back(3'd2);
    repeat (4) exp_q.push_back(3'd5);
    repeat (4) exp_q.push_back(3'd7);
    check("a4_num_starts", ch_log.size() - lb, exp_q.size());
    bad = 0;
    for (int j = 0; j < exp_q.size() && lb + j < ch_log.size(); j++)
      if (ch_log[lb + j] !== exp_q[j]) bad++;
    check("a4_order", bad, 0);
    vpat = '0;
    for (int c = 0; c < 8; c++) begin
      read_ch(3'(c), d, v);
      vpat[c] = v;
      if (c == 2) check("a4_rd_ch2", d, 2);
      if (c == 5) check("a4_rd_ch5", d, 200);
      if (c == 7) check("a4_rd_ch7", d, 4001);
    end
    check("a4_valid_pattern", vpat, 8'hA4);

    // empty mask: requests dropped for several periods
    e0 = edge_cnt; sd0 = sd_cnt;
    ch_mask = '0; tick(2); enable = 1'b1;
    tick(3 * P);
    enable = 1'b0;
    check("mask0_no_starts", edge_cnt - e0, 0);
    check("mask0_no_scan_done", sd_cnt - sd0, 0);

    // periodic rescans while enable held
    set_vals(0, 12'd8, 12'd8, 12'd8, 12'd8);
    sd0 = sd_cnt;
    ch_mask = 8'h01; tick(2); enable = 1'b1;
    tick(2 * P + 200);
    enable = 1'b0; tick(2);
    check("period_scans", sd_cnt - sd0, 3);
    read_ch(3'd0, d, v);
    check("period_rd_ch0", d, 8);

    // timeout on channel 3, channel 4 still converted
    do_reset();
    mdl_mute = 8'h08;
    set_vals(4, 12'd7, 12'd7, 12'd7, 12'd7);
    e0 = edge_cnt; sd0 = sd_cnt;
    ch_mask = 8'h18; tick(2); enable = 1'b1;
    for (int i = 0; i < 100 && edge_cnt == e0; i++) tick(1);
    tick(200);
    check("to_not_yet", timeout_err, 0);
    for (int i = 0; i < 1000 && sd_cnt == sd0; i++) tick(1);
    enable = 1'b0;
    tick(2);
    check("to_scan_done", sd_cnt - sd0, 1);
    check("to_err_set", timeout_err, 1);
    check("to_starts", edge_cnt - e0, 5);
    read_ch(3'd3, d, v);
    check("to_ch3_valid", v, 0);
    read_ch(3'd4, d, v);
    check("to_ch4_valid", v, 1);
    check("to_ch4_data", d, 7);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    check("to_err_cleared", timeout_err, 0);
    mdl_mute = '0;

    // enable dropped during the second sample of channel 1
    do_reset();
    set_vals(0, 12'd5, 12'd5, 12'd5, 12'd5);
    set_vals(1, 12'd40, 12'd40, 12'd40, 12'd40);
    run_scan(8'h03, 1000, ok);
    read_ch(3'd1, d, v);
    check("drop_pre_ch1", d, 40);
    set_vals(1, 12'd400, 12'd400, 12'd400, 12'd400);
    e0 = edge_cnt; sd0 = sd_cnt;
    ch_mask = 8'h03; tick(2); enable = 1'b1;
    for (int i = 0; i < 500 && edge_cnt < e0 + 6; i++) tick(1);
    check("drop_reached_sample", edge_cnt - e0, 6);
    enable = 1'b0;
    tick(30);
    check("drop_no_more_starts", edge_cnt - e0, 6);
    check("drop_no_scan_done", sd_cnt - sd0, 0);
    check("drop_start_low", measure_start, 0);
    read_ch(3'd1, d, v);
    check("drop_ch1_unchanged", d, 40);

    // reset while waiting for done; a late done is ignored
    e0 = edge_cnt; sd0 = sd_cnt;
    ch_mask = 8'h01; tick(2); enable = 1'b1;
    for (int i = 0; i < 100 && edge_cnt == e0; i++) tick(1);
    check("rw_started", edge_cnt - e0, 1);
    reset = 1'b1;
    #1;
    check("rw_start_async_low", measure_start, 0);
    enable = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    e0 = edge_cnt;
    inject_req++;
    tick(4);
    check("rw_no_start", edge_cnt - e0, 0);
    check("rw_no_scan_done", sd_cnt - sd0, 0);
    vpat = '0;
    for (int c = 0; c < 8; c++) begin
      read_ch(3'(c), d, v);
      vpat[c] = v;
    end
    check("rw_all_invalid", vpat, 0);
    read_ch(3'd0, d, v);
    check("rw_ch0_data", d, 0);

    check("ch_stable_before_start", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_scan_ctrl.md
Name: adc_scan_ctrl

Overview:
- Channel-scan sequencer sitting directly upstream and downstream of the LTC2308 converter interface.
- Drives that interface's start and channel inputs.
- Consumes its done pulse and 12-bit result, and averages 2^AVG_LOG2 conversions per channel.
- Publishes per-channel results to a readable bank for the HPS bridge and the flight-control logic.

Parameters:
- AVG_LOG2, 2, log2 of conversions averaged per channel per scan (0..4).
- SCAN_PERIOD, 40000, clk cycles from one scan start to the next (1 ms at 40 MHz).
- TIMEOUT, 255, max clk cycles waited for measure_done after a start.

Ports:
- clk  in  1  system clock, max 40 MHz, shared with converter interface
- reset  in  1  asynchronous, active-high reset
- enable  in  1  scanning allowed while high
- ch_mask  in  8  bit n = scan channel n
- measure_start  out  1  to converter; conversion triggered on its rising edge
- measure_ch  out  3  to converter; channel select
- measure_done  in  1  from converter; one-cycle pulse when result valid
- measure_dataread  in  12  from converter; conversion result
- rd_ch  in  3  result bank read address
- rd_data  out  12  averaged result for rd_ch, registered
- rd_valid  out  1  channel rd_ch has been written since reset, registered with rd_data
- scan_done  out  1  one-cycle pulse after last enabled channel stored
- timeout_err  out  1  sticky; set on any done timeout
- err_clr  in  1  clears timeout_err

Behaviour:
- Reset (asynchronous, active-high) clears all of the following:
  - measure_start=0, measure_ch=0, rd_data=0, rd_valid=0, scan_done=0, timeout_err=0;
  - result bank, valid bits, accumulator, counters; FSM returns to IDLE.
- Reset mid-conversion is allowed; the converter's in-flight done is ignored because FSM is in IDLE.
- Period counter: free-runs 0..SCAN_PERIOD-1 while enable=1; held at 0 while enable=0.
- Scan request: pends when the counter wraps or on the first cycle enable rises.
- FSM states:
  - IDLE: measure_start=0. If enable=1, a request is pending, and ch_mask!=0:
    - latch ch_mask into scan_mask;
    - find the lowest set bit; go SELECT.
    - If ch_mask==0, the request is dropped and no start is issued.
  - SELECT (1 cycle): measure_ch <= current channel; measure_start=0; clear timeout counter; go START.
    - Guarantees a low cycle before every rising edge and channel stable >=1 cycle before it.
  - START: measure_start=1; go WAIT_DONE.
  - WAIT_DONE: measure_start held 1; timeout counter increments.
    - On measure_done=1: acc <= acc + measure_dataread; go STORE.
    - If the counter reaches TIMEOUT first: set timeout_err; write nothing for this sample; go NEXT. Valid bit unchanged.
  - STORE (1 cycle): measure_start=0; sample count +1.
    - If count < 2^AVG_LOG2: go SELECT, same channel.
    - Otherwise: bank[ch] <= acc >> AVG_LOG2 (truncate, no rounding); valid[ch] <= 1; acc <= 0; go NEXT.
  - NEXT:
    - Clear sample count and acc.
    - Advance to the next higher set bit of scan_mask; go SELECT.
    - If none remain: pulse scan_done for 1 cycle; go IDLE.
    - If enable=0: go IDLE without further starts. Scan abandoned; partial acc discarded; no scan_done.
- Accumulator width is 12+AVG_LOG2 bits, so no overflow is possible (4095*16 fits in 16 bits).
- A scan longer than SCAN_PERIOD leaves one pending request; the next scan starts immediately from IDLE. Extra wraps are not queued.
- ch_mask changes mid-scan take effect at the next scan.
- measure_done outside WAIT_DONE is ignored.
- Read port: rd_data/rd_valid registered one cycle after rd_ch.
  - A read of the channel being written in the same cycle returns the old value.
- timeout_err: set has priority over err_clr in the same cycle.
- Latency per channel ≈ 2^AVG_LOG2 × (converter conversion time + 3 cycles).

Test Plan:
- Reset, enable=1, ch_mask=8'h01, AVG_LOG2=2, converter model returns 100,101,102,103 -> four rising edges of measure_start, each preceded by a low cycle, measure_ch=0; then rd_ch=0 gives rd_data=101, rd_valid=1, scan_done pulses once.
- ch_mask=8'hA4 -> channels 2, 5, 7 in that order, 4 starts each, rd_valid set for channels 2, 5, 7 only.
- ch_mask=0, enable=1 for 3×SCAN_PERIOD -> measure_start never rises, scan_done never pulses.
- Model never asserts done on channel 3 (mask 8'h18) -> timeout_err=1 after 255 cycles; channel 4 still converted; rd_valid[3]=0. err_clr then clears the flag.
- Drop enable during the second sample of channel 1 (mask 8'h03) -> that conversion completes, FSM goes IDLE, no scan_done, bank[1] unchanged.
- Assert reset during WAIT_DONE -> measure_start=0 immediately; all rd_valid=0; a late done pulse is ignored.
